// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants for the async-FIFO read-side stream adapter.
package fifo_rd_stream_adapter_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned CNT_WIDTH_DEF  = 16;
   localparam int unsigned SKID_DEPTH     = 2;
   localparam int unsigned OCC_WIDTH      = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer absorbing the FIFO's registered read latency.
module fifo_skid_buf
   import fifo_rd_stream_adapter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [OCC_WIDTH-1:0]  occ
);

   logic [DATA_WIDTH-1:0] tail;

   // Head is always the oldest word; tail only holds data when occ is full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == '0) head <= din;
               else           tail <= din;
               occ <= occ + OCC_WIDTH'(1);
            end
            2'b01: begin
               head <= tail;
               tail <= '0;
               occ  <= occ - OCC_WIDTH'(1);
            end
            2'b11: begin
               if (occ == OCC_WIDTH'(SKID_DEPTH)) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain FIFO consumer: issues reads, buffers returning words, and
// presents them as a valid/ready stream with a handshake counter.
module fifo_rd_stream_adapter
   import fifo_rd_stream_adapter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  rd_empty,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_ena,
   input  logic                  drain_en,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  xfer_count,
   output logic [OCC_WIDTH-1:0]  buf_occ
);

   localparam int unsigned DW = OCC_WIDTH + 1;

   logic          inflight;
   logic          pop;
   logic [DW-1:0] demand;
   logic [CNT_WIDTH-1:0] cnt;

   assign pop       = out_valid & out_ready;
   assign out_valid = (buf_occ != '0);

   // Words that will occupy the buffer after this edge if no new read is issued.
   assign demand = DW'(buf_occ) + DW'(inflight) - DW'(pop);
   assign rd_ena = ~rd_rst & drain_en & ~rd_empty & (demand < DW'(SKID_DEPTH));

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) inflight <= 1'b0;
      else        inflight <= rd_ena;
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)   cnt <= '0;
      else if (pop) cnt <= cnt + CNT_WIDTH'(1);
   end

   assign xfer_count = cnt;

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk  (rd_clk),
      .rst  (rd_rst),
      .push (inflight),
      .din  (rd_data),
      .pop  (pop),
      .head (out_data),
      .occ  (buf_occ)
   );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a registered-read FIFO model.
module tb_fifo_rd_stream_adapter;

   logic       rd_clk;
   logic       rd_rst;
   logic       rd_empty;
   logic [7:0] rd_data;
   logic       rd_ena;
   logic       drain_en;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [15:0] xfer_count;
   logic [1:0] buf_occ;

   int vec  = 0;
   int errs = 0;
   int cyc  = 0;

   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   int         ena_n = 0;
   int         rx_n  = 0;
   int         ena_cyc [0:255];
   int         rx_cyc  [0:255];
   logic [7:0] rx_data [0:255];

   logic [7:0] stream_words [0:10] = '{8'hAB, 8'hDE, 8'h01, 8'h99, 8'hEF, 8'h69,
                                       8'hBB, 8'h10, 8'h89, 8'h55, 8'hC9};

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .rd_empty   (rd_empty),
      .rd_data    (rd_data),
      .rd_ena     (rd_ena),
      .drain_en   (drain_en),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .xfer_count (xfer_count),
      .buf_occ    (buf_occ)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) cyc <= cyc + 1;

   // FIFO model: data appears the cycle after rd_ena
   assign rd_empty = (rd_ptr == wr_ptr);
   always @(posedge rd_clk) begin
      if (rd_ena) begin
         rd_data <= mem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   always @(negedge rd_clk) begin
      if (!rd_rst) begin
         if (rd_ena) begin
            ena_cyc[ena_n] = cyc;
            ena_n = ena_n + 1;
         end
         if (out_valid && out_ready) begin
            rx_data[rx_n] = out_data;
            rx_cyc[rx_n]  = cyc;
            rx_n = rx_n + 1;
         end
      end
   end

   task automatic push_word(input logic [7:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic next_cycle();
      @(posedge rd_clk);
      @(negedge rd_clk);
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; drain_en = 1'b1; out_ready = 1'b0;
      mem[0] = 8'h5A; wr_ptr = 1;
      repeat (3) @(negedge rd_clk);
      vec++; if (rd_ena !== 1'b0) begin errs++; $display("FAIL reset_rd_ena got=%b exp=0", rd_ena); end
      vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      vec++; if (xfer_count !== 16'h0000) begin errs++; $display("FAIL reset_xfer_count got=%h exp=0000", xfer_count); end
      vec++; if (buf_occ !== 2'd0) begin errs++; $display("FAIL reset_buf_occ got=%0d exp=0", buf_occ); end
      vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      wr_ptr = 0;
   endtask

   task automatic test_streaming();
      int be, br;
      @(posedge rd_clk); #1;
      out_ready = 1'b1; drain_en = 1'b1;
      be = ena_n; br = rx_n;
      for (int i = 0; i < 11; i++) push_word(stream_words[i]);
      rd_rst = 1'b0;
      repeat (20) @(negedge rd_clk);
      vec++; if (rx_n - br !== 11) begin errs++; $display("FAIL stream_count got=%0d exp=11", rx_n - br); end
      for (int i = 0; i < 11; i++) begin
         vec++;
         if (rx_data[br+i] !== stream_words[i]) begin
            errs++; $display("FAIL stream_word%0d got=%h exp=%h", i, rx_data[br+i], stream_words[i]);
         end
      end
      vec++; if (rx_cyc[br] - ena_cyc[be] !== 2) begin errs++; $display("FAIL stream_latency got=%0d exp=2", rx_cyc[br] - ena_cyc[be]); end
      vec++; if (rx_cyc[br+10] - rx_cyc[br] !== 10) begin errs++; $display("FAIL stream_rate got=%0d exp=10", rx_cyc[br+10] - rx_cyc[br]); end
      vec++; if (ena_n - be !== 11) begin errs++; $display("FAIL stream_ena_pulses got=%0d exp=11", ena_n - be); end
      vec++; if (xfer_count !== 16'd11) begin errs++; $display("FAIL stream_xfer_count got=%0d exp=11", xfer_count); end
      vec++; if (rd_ena !== 1'b0 || rd_empty !== 1'b1) begin errs++; $display("FAIL stream_idle rd_ena=%b rd_empty=%b exp 0/1", rd_ena, rd_empty); end
   endtask

   task automatic test_backpressure();
      int be, br;
      @(posedge rd_clk); #1;
      out_ready = 1'b0;
      be = ena_n; br = rx_n;
      for (int i = 0; i < 11; i++) push_word(stream_words[i]);
      repeat (10) @(negedge rd_clk);
      vec++; if (ena_n - be !== 2) begin errs++; $display("FAIL bp_ena_pulses got=%0d exp=2", ena_n - be); end
      vec++; if (buf_occ !== 2'd2) begin errs++; $display("FAIL bp_buf_occ got=%0d exp=2", buf_occ); end
      vec++; if (out_valid !== 1'b1 || out_data !== 8'hAB) begin errs++; $display("FAIL bp_head valid=%b data=%h exp 1/AB", out_valid, out_data); end
      vec++; if (rd_ena !== 1'b0) begin errs++; $display("FAIL bp_rd_ena got=%b exp=0", rd_ena); end
      repeat (3) @(negedge rd_clk);
      vec++; if (out_data !== 8'hAB || ena_n - be !== 2) begin errs++; $display("FAIL bp_hold data=%h pulses=%0d exp AB/2", out_data, ena_n - be); end
      @(posedge rd_clk); #1;
      out_ready = 1'b1;
      repeat (20) @(negedge rd_clk);
      vec++; if (rx_n - br !== 11) begin errs++; $display("FAIL bp_count got=%0d exp=11", rx_n - br); end
      for (int i = 0; i < 11; i++) begin
         vec++;
         if (rx_data[br+i] !== stream_words[i]) begin
            errs++; $display("FAIL bp_word%0d got=%h exp=%h", i, rx_data[br+i], stream_words[i]);
         end
      end
      vec++; if (ena_n - be !== 11) begin errs++; $display("FAIL bp_total_pulses got=%0d exp=11", ena_n - be); end
      vec++; if (xfer_count !== 16'd22) begin errs++; $display("FAIL bp_xfer_count got=%0d exp=22", xfer_count); end
   endtask

   task automatic test_simultaneous();
      int br;
      @(posedge rd_clk); #1;
      br = rx_n;
      for (int i = 1; i <= 8; i++) push_word(8'(i * 8'h11));
      @(negedge rd_clk);
      next_cycle();
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         vec++; if (buf_occ !== 2'd1) begin errs++; $display("FAIL sim_buf_occ%0d got=%0d exp=1", i, buf_occ); end
         vec++; if (rd_ena !== 1'b1) begin errs++; $display("FAIL sim_rd_ena%0d got=%b exp=1", i, rd_ena); end
         next_cycle();
      end
      repeat (12) @(negedge rd_clk);
      vec++; if (rx_n - br !== 8) begin errs++; $display("FAIL sim_count got=%0d exp=8", rx_n - br); end
      for (int i = 0; i < 8; i++) begin
         vec++;
         if (rx_data[br+i] !== 8'((i + 1) * 8'h11)) begin
            errs++; $display("FAIL sim_word%0d got=%h exp=%h", i, rx_data[br+i], 8'((i + 1) * 8'h11));
         end
      end
      vec++; if (xfer_count !== 16'd30) begin errs++; $display("FAIL sim_xfer_count got=%0d exp=30", xfer_count); end
   endtask

   task automatic test_drain_pause();
      int be, br;
      @(posedge rd_clk); #1;
      be = ena_n; br = rx_n;
      for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
      @(posedge rd_clk); #1;
      drain_en = 1'b0;
      repeat (6) @(negedge rd_clk);
      vec++; if (ena_n - be !== 1) begin errs++; $display("FAIL drain_ena_pulses got=%0d exp=1", ena_n - be); end
      vec++; if (rx_n - br !== 1) begin errs++; $display("FAIL drain_inflight_count got=%0d exp=1", rx_n - br); end
      vec++; if (rx_data[br] !== 8'hA0) begin errs++; $display("FAIL drain_inflight_word got=%h exp=A0", rx_data[br]); end
      vec++; if (rd_ena !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL drain_idle rd_ena=%b valid=%b exp 0/0", rd_ena, out_valid); end
      @(posedge rd_clk); #1;
      drain_en = 1'b1;
      repeat (12) @(negedge rd_clk);
      vec++; if (rx_n - br !== 6) begin errs++; $display("FAIL drain_resume_count got=%0d exp=6", rx_n - br); end
      for (int i = 1; i < 6; i++) begin
         vec++;
         if (rx_data[br+i] !== 8'hA0 + 8'(i)) begin
            errs++; $display("FAIL drain_word%0d got=%h exp=%h", i, rx_data[br+i], 8'hA0 + 8'(i));
         end
      end
      vec++; if (xfer_count !== 16'd36) begin errs++; $display("FAIL drain_xfer_count got=%0d exp=36", xfer_count); end
   endtask

   task automatic test_counter_wrap();
      int br;
      @(posedge rd_clk); #1;
      force dut.cnt = 16'hFFFF;
      #1;
      release dut.cnt;
      br = rx_n;
      push_word(8'hC0);
      push_word(8'hC1);
      repeat (8) @(negedge rd_clk);
      vec++; if (rx_n - br !== 2) begin errs++; $display("FAIL wrap_count got=%0d exp=2", rx_n - br); end
      vec++; if (xfer_count !== 16'h0001) begin errs++; $display("FAIL wrap_xfer_count got=%h exp=0001", xfer_count); end
   endtask

   task automatic test_reset_midstream();
      @(posedge rd_clk); #1;
      for (int i = 0; i < 6; i++) push_word(8'hD0 + 8'(i));
      repeat (3) @(negedge rd_clk);
      vec++; if (buf_occ !== 2'd1 || rd_ena !== 1'b1) begin errs++; $display("FAIL mid_pre occ=%0d rd_ena=%b exp 1/1", buf_occ, rd_ena); end
      #2;
      rd_rst = 1'b1;
      #1;
      vec++; if (rd_ena !== 1'b0) begin errs++; $display("FAIL mid_rd_ena got=%b exp=0", rd_ena); end
      vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
      vec++; if (buf_occ !== 2'd0) begin errs++; $display("FAIL mid_buf_occ got=%0d exp=0", buf_occ); end
      vec++; if (xfer_count !== 16'h0000) begin errs++; $display("FAIL mid_xfer_count got=%h exp=0000", xfer_count); end
      vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL mid_out_data got=%h exp=00", out_data); end
      drain_en = 1'b0;
      @(posedge rd_clk); #1;
      rd_rst = 1'b0;
      repeat (3) @(negedge rd_clk);
      vec++; if (out_valid !== 1'b0 || buf_occ !== 2'd0) begin errs++; $display("FAIL mid_lost_word valid=%b occ=%0d exp 0/0", out_valid, buf_occ); end
   endtask

   initial begin
      rd_rst    = 1'b1;
      drain_en  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_simultaneous();
      test_drain_pause();
      test_counter_wrap();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer for the async FIFO, running entirely in the read clock domain. Issues rd_ena into the FIFO whenever data is available and downstream space exists. Absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer. Presents words as a valid/ready stream and counts completed transfers.

Parameters:
DATA_WIDTH, 8, width of FIFO words and of out_data
CNT_WIDTH, 16, width of the transfer counter xfer_count

Ports:
rd_clk  input  1  read-domain clock; all logic is on its rising edge
rd_rst  input  1  reset, asynchronous, active-high
rd_empty  input  1  FIFO empty flag, synchronous to rd_clk
rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_ena=1
rd_ena  output  1  FIFO read strobe; pops one word per cycle when high
drain_en  input  1  allows new FIFO reads when 1
out_valid  output  1  out_data holds a word
out_data  output  DATA_WIDTH  head word of the skid buffer
out_ready  input  1  downstream accepts the word this cycle
xfer_count  output  CNT_WIDTH  number of completed out handshakes, modulo 2^CNT_WIDTH
buf_occ  output  2  skid buffer occupancy, 0..2

Behaviour:
- Interface: one clock, rd_clk. Reset rd_rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, buf_occ=0, xfer_count=0, internal inflight=0, both buffer entries=0.
- rd_ena is forced to 0 while rd_rst=1, independent of rd_empty.
- pop = out_valid & out_ready.
- rd_ena = drain_en & !rd_empty & ((buf_occ + inflight - pop) < 2). This is combinational; rd_ena depends on out_ready.
- inflight is a register loaded with rd_ena every cycle.
- Capture: when inflight=1, rd_data is written into the buffer tail on that edge. It is never dropped; the space check guarantees room.
- Buffer is an in-order 2-entry FIFO (head/tail regs or shift). out_valid = (buf_occ != 0). out_data = head entry, registered.
- Occupancy update per edge, with cap = inflight:
  - cap only: +1
  - pop only: -1
  - cap and pop: unchanged, and the next word becomes head correctly
  - buf_occ never exceeds 2 and never underflows.
- Latency: rd_ena high in cycle N → rd_data sampled at end of N+1 → out_valid=1 in cycle N+2 with that word.
- Throughput: 1 word/cycle sustained while rd_empty=0, drain_en=1 and out_ready=1.
- Backpressure: with out_ready=0, at most 2 words are read (buffer full) and rd_ena then stays 0. Words must not be lost or duplicated.
- drain_en=0: no new rd_ena. An in-flight word is still captured, and buffered words still drain through out_ready.
- rd_empty=1: rd_ena=0. A word already in flight is still captured.
- out_valid/out_data are stable while out_valid=1 and out_ready=0.
- xfer_count increments by 1 on each pop and wraps from all-ones to 0.
- Reset mid-operation:
  - clears buffer, inflight and counter immediately (async).
  - A word whose rd_ena was issued before reset is lost. This is accepted: the FIFO's rd_rst resets its pointers in the same domain.

Decomposition:
- Shared package holds: DATA_WIDTH default; CNT_WIDTH default; skid depth constant SKID_DEPTH=2.
- One natural sub-module: fifo_skid_buf (2-entry buffer with push/pop/occ).
- Top level contains the rd_ena issue logic, the inflight register and the counter.

Test Plan:
1. Reset: hold rd_rst=1 with rd_empty=0 and drain_en=1 → rd_ena=0, out_valid=0, xfer_count=0, buf_occ=0.
2. Streaming: FIFO model preloaded AB,DE,01,99,EF,69,BB,10,89,55,C9; out_ready=1; drain_en=1.
   - out_data sequence matches in order, one per cycle.
   - first out_valid 2 cycles after first rd_ena.
   - xfer_count=11 at end; rd_ena drops when rd_empty rises.
3. Backpressure: same preload, out_ready=0.
   - exactly 2 rd_ena pulses; buf_occ=2; out_data=AB held stable.
   - release out_ready → remaining words arrive in order, no loss or duplication.
4. Simultaneous events: steady stream with buf_occ=1 and inflight=1, out_ready=1 → buf_occ stays 1 and rd_ena stays high every cycle.
5. drain_en toggled 0 during stream with one word in flight → that word is still delivered, then rd_ena=0 until drain_en=1.
6. Counter wrap: force xfer_count to FFFF, perform 2 handshakes → xfer_count=0001. Also assert rd_rst mid-stream → all outputs return to reset values in the same cycle.
